// File: rtl/prio_enc_stream_pkg.sv
// ---------------------------------------------------------------------------
// Package: pcode_pkg
// Purpose: shared types and helpers for the streaming priority encoder.
//          Holds the two-state FSM encoding and a "one or zero bits set"
//          helper used for last-beat detection.
// Contents:
//   pe_state_t       IDLE / SCAN
//   PE_MAX_W         widest request vector the helper function can inspect
//   onehot_or_zero() true when at most one bit of the vector is set
// ---------------------------------------------------------------------------
package pcode_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } pe_state_t;

   // Packages cannot carry per-instance widths, so the helper works on a
   // fixed-width container and callers zero-extend into it.
   localparam int PE_MAX_W = 64;

   // Clearing the lowest set bit leaves zero exactly when there was at most
   // one bit set to begin with.
   function automatic logic onehot_or_zero(input logic [PE_MAX_W-1:0] v);
      return (v & (v - PE_MAX_W'(1))) == '0;
   endfunction

endpackage

// File: rtl/prio_enc_stream_if.sv
// ---------------------------------------------------------------------------
// Interface: prio_enc_stream_if
// Purpose: bundles the request-side and beat-side handshakes of the
//          streaming priority encoder.
// Signals:
//   in_valid / in_ready / in_vec                     request vector stream
//   out_valid / out_ready / out_code / out_last /
//   out_none                                         index beat stream
// Modports:
//   master  producer of vectors and consumer of beats (e.g. a testbench)
//   slave   the encoder itself
// ---------------------------------------------------------------------------
interface prio_enc_stream_if #(
   parameter int WIDTH  = 8,
   parameter int CODE_W = $clog2(WIDTH)
);

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_vec;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_code;
   logic              out_last;
   logic              out_none;

   modport master (
      output in_valid,
      output in_vec,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_code,
      input  out_last,
      input  out_none
   );

   modport slave (
      input  in_valid,
      input  in_vec,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_code,
      output out_last,
      output out_none
   );

endinterface

// File: rtl/prio_enc_stream_enc.sv
// ---------------------------------------------------------------------------
// Module: prio_enc
// Purpose: purely combinational WIDTH-bit priority encoder, the generalised
//          form of the legacy 8-to-3 encoder.
// Parameters:
//   WIDTH      request vector width
//   LSB_FIRST  0: highest set index wins; 1: lowest set index wins
//   CODE_W     index width, derived
// Ports:
//   vec   in   WIDTH   vector to encode
//   code  out  CODE_W  index of the winning bit (0 when vec is all-zero)
//   any   out  1       at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_enc #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0,
   parameter int CODE_W    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]  vec,
   output logic [CODE_W-1:0] code,
   output logic              any
);

   // The last matching bit in loop order wins, so the scan direction is the
   // opposite of the priority direction.
   always_comb begin
      code = '0;
      if (LSB_FIRST) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) code = CODE_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) code = CODE_W'(i);
         end
      end
   end

   assign any = |vec;

endmodule

// File: rtl/prio_enc_stream.sv
// ---------------------------------------------------------------------------
// Module: prio_enc_stream
// Purpose: accepts a WIDTH-bit request vector over a valid/ready handshake
//          and emits the index of every set bit, one per beat, in priority
//          order. An all-zero vector yields a single "none" beat.
// Parameters:
//   WIDTH      request vector width, >= 2 and <= 64
//   LSB_FIRST  0: highest set index first; 1: lowest set index first
//   CODE_W     derived index width, not to be overridden
// Ports:
//   clk    in  1  clock, all state on rising edge
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of prio_enc_stream_if carrying both streams
// ---------------------------------------------------------------------------
module prio_enc_stream
   import pcode_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0,
   parameter int CODE_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   prio_enc_stream_if.slave bus
);

   pe_state_t         state;
   pe_state_t         state_next;
   logic [WIDTH-1:0]  pending;
   logic [WIDTH-1:0]  pending_next;
   logic              none_q;
   logic              none_next;

   logic [CODE_W-1:0] enc_code;
   logic              enc_any;
   logic              single_bit;
   logic              in_fire;
   logic              out_fire;
   logic [WIDTH-1:0]  clr_mask;

   prio_enc #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST),
      .CODE_W    (CODE_W)
   ) u_enc (
      .vec  (pending),
      .code (enc_code),
      .any  (enc_any)
   );

   assign single_bit = onehot_or_zero(PE_MAX_W'(pending));

   // Outputs are driven to zero outside SCAN so the beat stream never shows
   // stale codes. in_ready opens in SCAN only on the cycle the last beat is
   // taken, letting the next vector load without an idle bubble.
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_code  = '0;
      bus.out_last  = 1'b0;
      bus.out_none  = 1'b0;
      if (state == SCAN) begin
         bus.out_valid = 1'b1;
         bus.out_none  = none_q;
         bus.out_last  = none_q | single_bit;
         if (!none_q && enc_any) bus.out_code = enc_code;
      end
      out_fire     = bus.out_valid & bus.out_ready;
      bus.in_ready = (state == IDLE) | (out_fire & bus.out_last);
      in_fire      = bus.in_valid & bus.in_ready;
   end

   // One-hot mask of the bit currently being presented, cleared once the
   // consumer takes the beat.
   always_comb begin
      clr_mask           = '0;
      clr_mask[enc_code] = 1'b1;
   end

   // Next-state logic: load on any accepted vector, otherwise retire the
   // presented bit on a non-final beat, or fall back to IDLE after the final
   // beat when no new vector is waiting.
   always_comb begin
      state_next   = state;
      pending_next = pending;
      none_next    = none_q;
      case (state)
         IDLE: begin
            if (in_fire) begin
               state_next   = SCAN;
               pending_next = bus.in_vec;
               none_next    = (bus.in_vec == '0);
            end
         end
         SCAN: begin
            if (out_fire) begin
               if (bus.out_last) begin
                  if (in_fire) begin
                     state_next   = SCAN;
                     pending_next = bus.in_vec;
                     none_next    = (bus.in_vec == '0);
                  end else begin
                     state_next   = IDLE;
                     pending_next = '0;
                     none_next    = 1'b0;
                  end
               end else begin
                  pending_next = pending & ~clr_mask;
               end
            end
         end
         default: begin
            state_next   = IDLE;
            pending_next = '0;
            none_next    = 1'b0;
         end
      endcase
   end

   // State registers; reset discards any in-flight vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
         none_q  <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         none_q  <= none_next;
      end
   end

endmodule

// File: tb/tb_prio_enc_stream.sv
// ---------------------------------------------------------------------------
// Testbench: tb_prio_enc_stream
// Purpose: directed checks of the streaming priority encoder in its default
//          8-bit MSB-first form and a 16-bit LSB-first form.
// ---------------------------------------------------------------------------
module tb_prio_enc_stream;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   prio_enc_stream_if #(.WIDTH(8))  bus8  ();
   prio_enc_stream_if #(.WIDTH(16)) bus16 ();

   prio_enc_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   prio_enc_stream #(.WIDTH(16), .LSB_FIRST(1'b1)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Each comparison is one immediate assertion that bumps the run count and,
   // on a miss, the failure count.
   task automatic check_output(input string tag, input int observed, input int expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Checks every beat-side output of the 8-bit instance plus in_ready.
   task automatic check_beat8(input string tag, input int valid, input int code,
                              input int last, input int none, input int ready);
      check_output({tag, ".out_valid"}, int'(bus8.out_valid), valid);
      check_output({tag, ".out_code"},  int'(bus8.out_code),  code);
      check_output({tag, ".out_last"},  int'(bus8.out_last),  last);
      check_output({tag, ".out_none"},  int'(bus8.out_none),  none);
      check_output({tag, ".in_ready"},  int'(bus8.in_ready),  ready);
   endtask

   task automatic check_beat16(input string tag, input int valid, input int code,
                               input int last, input int ready);
      check_output({tag, ".out_valid"}, int'(bus16.out_valid), valid);
      check_output({tag, ".out_code"},  int'(bus16.out_code),  code);
      check_output({tag, ".out_last"},  int'(bus16.out_last),  last);
      check_output({tag, ".in_ready"},  int'(bus16.in_ready),  ready);
   endtask

   // Moves from one falling edge, across a rising edge, to the next falling
   // edge; inputs change and outputs are sampled only at falling edges.
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      rst_n           = 1'b0;
      bus8.in_valid   = 1'b0;
      bus8.in_vec     = '0;
      bus8.out_ready  = 1'b1;
      bus16.in_valid  = 1'b0;
      bus16.in_vec    = '0;
      bus16.out_ready = 1'b1;

      @(negedge clk);
      #1;
      check_beat8("reset", 0, 0, 0, 0, 1);
      check_beat16("reset16", 0, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // MSB-first scan of 1010_0100: 7, 5, 2 on consecutive cycles.
      bus8.in_valid = 1'b1;
      bus8.in_vec   = 8'b1010_0100;
      check_beat8("t1.idle", 0, 0, 0, 0, 1);
      next_cycle();
      bus8.in_valid = 1'b0;
      bus8.in_vec   = 8'hFF;
      check_beat8("t1.b0", 1, 7, 0, 0, 0);
      next_cycle();
      check_beat8("t1.b1", 1, 5, 0, 0, 0);
      next_cycle();
      check_beat8("t1.b2", 1, 2, 1, 0, 1);
      next_cycle();
      check_beat8("t1.done", 0, 0, 0, 0, 1);

      // All-zero vector: one none beat, then back to IDLE.
      bus8.in_valid = 1'b1;
      bus8.in_vec   = 8'h00;
      next_cycle();
      bus8.in_valid = 1'b0;
      check_beat8("t2.b0", 1, 0, 1, 1, 1);
      next_cycle();
      check_beat8("t2.done", 0, 0, 0, 0, 1);

      // Back-pressure on the first beat of 8'h24 holds code 5 stable.
      bus8.in_valid  = 1'b1;
      bus8.in_vec    = 8'h24;
      bus8.out_ready = 1'b0;
      next_cycle();
      bus8.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_beat8($sformatf("t3.hold%0d", i), 1, 5, 0, 0, 0);
         next_cycle();
      end
      bus8.out_ready = 1'b1;
      #1;
      check_beat8("t3.b0", 1, 5, 0, 0, 0);
      next_cycle();
      check_beat8("t3.b1", 1, 2, 1, 0, 1);
      next_cycle();
      check_beat8("t3.done", 0, 0, 0, 0, 1);

      // 16-bit LSB-first instance, 16'h8001: 0 then 15 (last).
      bus16.in_valid = 1'b1;
      bus16.in_vec   = 16'h8001;
      next_cycle();
      bus16.in_valid = 1'b0;
      check_beat16("t4.b0", 1, 0, 0, 0);
      next_cycle();
      check_beat16("t4.b1", 1, 15, 1, 1);
      next_cycle();
      check_beat16("t4.done", 0, 0, 0, 1);

      // Back-to-back 8'h80 then 8'h03 with in_valid held: no bubble.
      bus8.in_valid = 1'b1;
      bus8.in_vec   = 8'h80;
      next_cycle();
      bus8.in_vec = 8'h03;
      #1;
      check_beat8("t5.b0", 1, 7, 1, 0, 1);
      next_cycle();
      bus8.in_valid = 1'b0;
      #1;
      check_beat8("t5.b1", 1, 1, 0, 0, 0);
      next_cycle();
      check_beat8("t5.b2", 1, 0, 1, 0, 1);
      next_cycle();
      check_beat8("t5.done", 0, 0, 0, 0, 1);

      // Reset during beat 2 of 8'hFF drops the beat immediately.
      bus8.in_valid = 1'b1;
      bus8.in_vec   = 8'hFF;
      next_cycle();
      bus8.in_valid = 1'b0;
      check_beat8("t6.b0", 1, 7, 0, 0, 0);
      next_cycle();
      check_beat8("t6.b1", 1, 6, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check_beat8("t6.rst", 0, 0, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      bus8.in_valid = 1'b1;
      bus8.in_vec   = 8'h10;
      #1;
      check_beat8("t6.idle", 0, 0, 0, 0, 1);
      next_cycle();
      bus8.in_valid = 1'b0;
      check_beat8("t6.next", 1, 4, 1, 0, 1);
      next_cycle();
      check_beat8("t6.done", 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
